conv1d_pe_row: RTL

Weight-stationary 1-D convolution row engine that produces the 8-bit partial-sum stream consumed by the partial-sum accumulator stage. It loads K weights, streams activations through a K-tap window, and emits one saturated psum per activation beat once the window is full. It also emits a frame-level enable that drives the accumulator's `en`: the accumulator clears while `en` is low and accumulates every cycle while `en` is high.

---
 rtl/conv1d_pe_row.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/conv1d_pe_row.sv
// rtl/conv1d_pe_row.sv - weight-stationary K-tap 1-D convolution row engine
//
// Loads K unsigned 8-bit weights, slides a K-entry activation window and
// emits one saturated 8-bit psum per activation beat once the window is full.
// psum_en frames the psum stream for the downstream accumulator.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   w_valid/w_data  weight beats, beat n loads w[n]; w_ready high in IDLE/LOAD/READY
//   act_valid/act_data/act_last
//                   activation beats; act_ready high in READY/FILL/RUN
//   psum_out        saturated window sum, 0 when psum_valid is low
//   psum_valid      psum_out carries a window result
//   psum_en         frame-active enable toward the accumulator
//   done            one-cycle end-of-frame pulse
//   gap_err         sticky: a RUN cycle without an activation beat

module conv1d_pe_row #(
   parameter int K = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       w_valid,
   input  logic [7:0] w_data,
   output logic       w_ready,
   input  logic       act_valid,
   input  logic [7:0] act_data,
   input  logic       act_last,
   output logic       act_ready,
   output logic [7:0] psum_out,
   output logic       psum_valid,
   output logic       psum_en,
   output logic       done,
   output logic       gap_err
);

   localparam int IW = $clog2(K);
   localparam int FW = $clog2(K + 1);
   localparam int SW = 16 + $clog2(K);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_FILL, S_RUN} state_t;

   state_t          state, state_n;
   logic [7:0]      w [K];
   logic [7:0]      x [K];
   logic [7:0]      x_shift [K];
   logic [IW-1:0]   idx, idx_n, widx_sel;
   logic [FW-1:0]   fill_cnt, fill_n;
   logic [SW-1:0]   sum;
   logic [7:0]      sat_psum;
   logic            w_fire, act_take;
   logic            w_load, win_shift, win_clear, gap_set;
   logic            p1_valid_n, p1_done_n;
   logic            p1_valid, p1_done;
   logic [7:0]      p1_psum;

   assign w_ready   = (state == S_IDLE) || (state == S_LOAD) || (state == S_READY);
   assign act_ready = (state == S_READY) || (state == S_FILL) || (state == S_RUN);
   assign w_fire    = w_valid && w_ready;
   // In READY both handshakes are open; a weight beat wins and the activation is dropped.
   assign act_take  = act_valid && act_ready && !w_fire;
   assign widx_sel  = (state == S_LOAD) ? idx : '0;

   // Window as it will look after the current beat shifts in; the psum is taken
   // from this so the window may be cleared on the same edge as the last beat.
   always_comb begin
      for (int j = 0; j < K - 1; j++) x_shift[j] = x[j + 1];
      x_shift[K-1] = act_data;
   end

   always_comb begin
      sum = '0;
      for (int j = 0; j < K; j++) sum = sum + SW'(16'(w[j]) * 16'(x_shift[j]));
      sat_psum = (sum > SW'(255)) ? 8'hFF : sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      fill_n     = fill_cnt;
      w_load     = 1'b0;
      win_shift  = 1'b0;
      win_clear  = 1'b0;
      gap_set    = 1'b0;
      p1_valid_n = 1'b0;
      p1_done_n  = 1'b0;
      case (state)
         S_IDLE, S_READY: begin
            if (w_fire) begin
               w_load  = 1'b1;
               idx_n   = IW'(1);
               state_n = S_LOAD;
            end else if (act_take) begin
               win_shift = 1'b1;
               if (act_last) begin
                  // single-beat frame: never fills, done only
                  win_clear = 1'b1;
                  p1_done_n = 1'b1;
                  fill_n    = '0;
               end else begin
                  fill_n  = FW'(1);
                  state_n = S_FILL;
               end
            end
         end
         S_LOAD: begin
            if (w_fire) begin
               w_load = 1'b1;
               if (idx == IW'(K - 1)) begin
                  idx_n   = '0;
                  state_n = S_READY;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end
         end
         S_FILL: begin
            if (act_take) begin
               win_shift = 1'b1;
               if (fill_cnt == FW'(K - 1)) begin
                  p1_valid_n = 1'b1;
                  if (act_last) begin
                     win_clear = 1'b1;
                     p1_done_n = 1'b1;
                     fill_n    = '0;
                     state_n   = S_READY;
                  end else begin
                     fill_n  = FW'(K);
                     state_n = S_RUN;
                  end
               end else if (act_last) begin
                  win_clear = 1'b1;
                  p1_done_n = 1'b1;
                  fill_n    = '0;
                  state_n   = S_READY;
               end else begin
                  fill_n = fill_cnt + FW'(1);
               end
            end
         end
         S_RUN: begin
            if (act_take) begin
               win_shift  = 1'b1;
               p1_valid_n = 1'b1;
               if (act_last) begin
                  win_clear = 1'b1;
                  p1_done_n = 1'b1;
                  fill_n    = '0;
                  state_n   = S_READY;
               end
            end else begin
               // accumulator will integrate a zero this cycle
               gap_set = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         fill_cnt   <= '0;
         for (int j = 0; j < K; j++) begin
            w[j] <= 8'd0;
            x[j] <= 8'd0;
         end
         p1_valid   <= 1'b0;
         p1_done    <= 1'b0;
         p1_psum    <= 8'd0;
         psum_valid <= 1'b0;
         psum_out   <= 8'd0;
         done       <= 1'b0;
         psum_en    <= 1'b0;
         gap_err    <= 1'b0;
      end else begin
         idx      <= idx_n;
         fill_cnt <= fill_n;
         if (w_load) w[widx_sel] <= w_data;
         if (win_clear) begin
            for (int j = 0; j < K; j++) x[j] <= 8'd0;
         end else if (win_shift) begin
            for (int j = 0; j < K; j++) x[j] <= x_shift[j];
         end
         // two-stage output: window update at edge t, psum visible after edge t+1
         p1_valid   <= p1_valid_n;
         p1_done    <= p1_done_n;
         p1_psum    <= p1_valid_n ? sat_psum : 8'd0;
         psum_valid <= p1_valid;
         psum_out   <= p1_psum;
         done       <= p1_done;
         // high from the first psum through the done cycle
         if (p1_valid)  psum_en <= 1'b1;
         else if (done) psum_en <= 1'b0;
         if (w_fire)       gap_err <= 1'b0;
         else if (gap_set) gap_err <= 1'b1;
      end
   end

endmodule
